// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-addressed data memory with level-sensitive write.
// Byte/half stores use a read-modify-write sequence; loads return the extended lane.
module lsu_rmw #(
  parameter int WORD_ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state, state_next;

  logic [WORD_ADDR_W-1:0] word_q;
  logic [1:0]             lane_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic                   write_q;
  logic [31:0]            wdata_q;
  logic [31:0]            old_word_q;
  logic [31:0]            rdata_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    req_err = 1'b0;
    if (req_size == 2'b11)                              req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])             req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)  req_err = 1'b1;
    if (req_addr[31:WORD_ADDR_W+2] != '0)               req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                              state_next = S_ERR;
          else if (req_write && req_size == SZ_WORD) state_next = S_WR;
          else                                      state_next = S_RD;
        end
      end
      S_RD:    state_next = write_q ? S_WR : S_RESP;
      S_WR:    state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads, straight off the combinational memory read.
  always_comb begin
    lane_byte = mem_readData[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? mem_readData[31:16] : mem_readData[15:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_val = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_val = mem_readData;
    endcase
  end

  always_comb begin
    merged = old_word_q;
    case (size_q)
      SZ_BYTE: merged[{lane_q, 3'b000} +: 8]        = wdata_q[7:0];
      SZ_HALF: merged[{lane_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // NOTE: datapath registers are reset too, so nothing stale can leak onto the outputs after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      old_word_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        word_q   <= req_addr[WORD_ADDR_W+1:2];
        lane_q   <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state == S_RD) begin
        if (write_q) old_word_q <= mem_readData;
        else         rdata_q    <= load_val;
      end
    end
  end

  // Strobes are decoded from the state register alone: the memory write is level-sensitive.
  always_comb begin
    req_ready     = (state == S_IDLE);
    resp_valid    = (state == S_RESP) || (state == S_ERR);
    resp_err      = (state == S_ERR);
    resp_rdata    = (state == S_RESP) ? rdata_q : '0;
    mem_memRead   = (state == S_RD);
    mem_memWrite  = (state == S_WR);
    mem_address   = '0;
    mem_writeData = '0;
    if (state == S_RD || state == S_WR)
      mem_address = {{(32-WORD_ADDR_W){1'b0}}, word_q};
    if (state == S_WR)
      mem_writeData = merged;
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed self-checking bench for lsu_rmw with a 256-word behavioural data memory.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  lsu_rmw #(.WORD_ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  logic        mem_clr;
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_memWrite) begin
      mem[mem_address[7:0]] <= mem_writeData;
    end
  end

  assign mem_readData = mem[mem_address[7:0]];

  int          wr_cnt   = 0;
  int          resp_cnt = 0;
  logic [31:0] last_wd  = '0;

  always @(negedge clk) begin
    if (mem_memWrite) begin
      wr_cnt  = wr_cnt + 1;
      last_wd = mem_writeData;
    end
    if (resp_valid) resp_cnt = resp_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for its response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd,
                       output int nwr);
    int w0;
    w0  = wr_cnt;
    lat = 0;
    err = 1'b0;
    rd  = '0;
    @(negedge clk);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        err = resp_err;
        rd  = resp_rdata;
        break;
      end
    end
    nwr = wr_cnt - w0;
  endtask

  int          lat, nwr;
  logic        err;
  logic [31:0] rd;

  logic [31:0] e_addr [4] = '{32'h06, 32'h05, 32'h00, 32'h400};
  logic [1:0]  e_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};

  logic [31:0] q_addr [3] = '{32'h10, 32'h12, 32'h01};
  logic [1:0]  q_size [3] = '{2'b10, 2'b01, 2'b00};
  logic        q_sgn  [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] q_exp  [3] = '{32'h1234BEEF, 32'h00001234, 32'hFFFFFFAA};

  initial begin
    int acc, nresp, r0, w0;
    int acc_cyc [3];

    reset      = 1'b1;
    mem_clr    = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  req_ready,     1);
    check("rst_resp_valid", resp_valid,    0);
    check("rst_resp_err",   resp_err,      0);
    check("rst_resp_rdata", resp_rdata,    0);
    check("rst_mem_addr",   mem_address,   0);
    check("rst_mem_wdata",  mem_writeData, 0);
    check("rst_mem_write",  mem_memWrite,  0);
    check("rst_mem_read",   mem_memRead,   0);
    @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;

    // Word store then signed byte load from the top lane.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, nwr);
    check("sw_lat",   lat, 2);
    check("sw_err",   err, 0);
    check("sw_rdata", rd,  0);
    check("sw_nwr",   nwr, 1);
    check("sw_wdata", last_wd, 32'hDEADBEEF);
    check("sw_mem4",  mem[4],  32'hDEADBEEF);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, rd, nwr);
    check("lb13_lat",   lat, 2);
    check("lb13_rdata", rd,  32'hFFFFFFDE);
    check("lb13_nwr",   nwr, 0);

    // Half store over the upper lane of the same word.
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, lat, err, rd, nwr);
    check("sh_lat",   lat, 3);
    check("sh_nwr",   nwr, 1);
    check("sh_wdata", last_wd, 32'h1234BEEF);
    check("sh_mem4",  mem[4],  32'h1234BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, err, rd, nwr);
    check("lhu12_lat",   lat, 2);
    check("lhu12_rdata", rd,  32'h00001234);

    // Byte store into a zeroed word; upper wdata bits must be ignored.
    issue(1'b1, 2'b00, 1'b0, 32'h01, 32'h123456AA, lat, err, rd, nwr);
    check("sb_lat",   lat, 3);
    check("sb_wdata", last_wd, 32'h0000AA00);
    check("sb_mem0",  mem[0],  32'h0000AA00);
    issue(1'b0, 2'b00, 1'b1, 32'h01, 32'h0, lat, err, rd, nwr);
    check("lb01_rdata", rd, 32'hFFFFFFAA);
    issue(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, lat, err, rd, nwr);
    check("lbu01_rdata", rd, 32'h000000AA);

    // Error requests, issued as stores so a stray write would show.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, e_size[i], 1'b0, e_addr[i], 32'hFFFFFFFF, lat, err, rd, nwr);
      check($sformatf("err%0d_lat", i),   lat, 1);
      check($sformatf("err%0d_err", i),   err, 1);
      check($sformatf("err%0d_rdata", i), rd,  0);
      check($sformatf("err%0d_nwr", i),   nwr, 0);
    end
    check("err_mem0", mem[0], 32'h0000AA00);
    check("err_mem1", mem[1], 32'h0);

    // Highest word is legal.
    issue(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, lat, err, rd, nwr);
    check("top_st_err", err, 0);
    check("top_mem255", mem[255], 32'hCAFEF00D);
    issue(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, lat, err, rd, nwr);
    check("top_lh_rdata", rd, 32'hFFFFCAFE);

    // Three loads with req_valid held high.
    acc   = 0;
    nresp = 0;
    @(negedge clk);
    req_write  = 1'b0;
    req_addr   = q_addr[0];
    req_size   = q_size[0];
    req_signed = q_sgn[0];
    req_valid  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (resp_valid) begin
        if (nresp < 3) begin
          check("q_rdata", resp_rdata, q_exp[nresp]);
          check("q_lat", c, acc_cyc[nresp] + 2);
        end
        check("q_ready_resp", req_ready, 0);
        nresp++;
      end
      if (mem_memRead) check("q_ready_rd", req_ready, 0);
      if (req_valid && req_ready && acc < 3) begin
        acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc >= 3) begin
        req_valid = 1'b0;
      end else begin
        req_addr   = q_addr[acc];
        req_size   = q_size[acc];
        req_signed = q_sgn[acc];
      end
      @(negedge clk);
    end
    check("q_count", nresp, 3);

    // Reset during the read phase of a byte store.
    r0 = resp_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h21;
    req_wdata  = 32'h55;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_rd_strobe", mem_memRead, 1);
    check("mid_rd_addr",   mem_address, 8);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_read",  mem_memRead,  0);
    check("mid_rst_write", mem_memWrite, 0);
    check("mid_rst_addr",  mem_address,  0);
    check("mid_rst_ready", req_ready,    1);
    check("mid_rst_resp",  resp_valid,   0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_nwr",   wr_cnt - w0,   0);
    check("mid_rst_nresp", resp_cnt - r0, 0);
    check("mid_rst_mem8",  mem[8],        0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr);
    check("post_rst_lat",   lat, 2);
    check("post_rst_rdata", rd,  32'h1234BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
